// File: rtl/i_fetch_stage.sv
// Instruction-fetch stage: owns the PC, a handshaked instruction-memory port and the IF/ID register.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_CNT_EN is defined.
module i_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_out,
   output logic [31:0] npc_out,
   output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        squash_reg, squash_next;
   logic [31:0] buf_reg, buf_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] npc_reg, npc_next;
   logic        valid_reg, valid_next;
   logic        load;
   logic [31:0] load_data;
   logic [31:0] pc_plus4;
   logic        consume;

   assign pc_plus4 = pc_reg + 32'd4;
   assign consume  = PCWrite & IFIDWrite;

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      squash_next = squash_reg;
      buf_next    = buf_reg;
      instr_next  = instr_reg;
      npc_next    = npc_reg;
      valid_next  = valid_reg;
      load        = 1'b0;
      load_data   = imem_rdata;

      if (pc_src) begin
         // Redirect overrides stalls; any in-flight response gets squashed.
         pc_next    = {pc_target[31:2], 2'b00};
         instr_next = NOP_INSTR;
         valid_next = 1'b0;
         case (state_reg)
            S_REQ: begin
               if (imem_ack) begin
                  state_next  = S_WAIT;
                  squash_next = 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_next  = S_REQ;
                  squash_next = 1'b0;
               end else begin
                  squash_next = 1'b1;
               end
            end
            default: state_next = S_REQ;
         endcase
      end else begin
         case (state_reg)
            S_REQ: begin
               if (imem_ack) state_next = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (squash_reg) begin
                     squash_next = 1'b0;
                     state_next  = S_REQ;
                  end else if (consume) begin
                     load       = 1'b1;
                     state_next = S_REQ;
                  end else begin
                     buf_next   = imem_rdata;
                     state_next = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (consume) begin
                  load       = 1'b1;
                  load_data  = buf_reg;
                  state_next = S_REQ;
               end
            end
            default: state_next = S_REQ;
         endcase

         if (load) begin
            instr_next = load_data;
            npc_next   = pc_plus4;
            valid_next = 1'b1;
            pc_next    = pc_plus4;
         end else if (IFIDWrite) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg  <= S_REQ;
         pc_reg     <= RESET_PC;
         squash_reg <= 1'b0;
         buf_reg    <= 32'h0;
         instr_reg  <= NOP_INSTR;
         npc_reg    <= 32'h0;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         squash_reg <= squash_next;
         buf_reg    <= buf_next;
         instr_reg  <= instr_next;
         npc_reg    <= npc_next;
         valid_reg  <= valid_next;
      end
   end

   // Request is masked during reset because the reset state is S_REQ.
   assign imem_req        = (state_reg == S_REQ) & ~RST;
   assign imem_addr       = pc_reg;
   assign instruction_out = instr_reg;
   assign npc_out         = npc_reg;
   assign valid_out       = valid_reg;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_reg, stall_count_reg;
   logic        stall_inc;

   assign stall_inc = (state_reg == S_HOLD) | (~pc_src & ~load & ~IFIDWrite);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_count_reg <= 32'h0;
         stall_count_reg <= 32'h0;
      end else begin
         if (load) fetch_count_reg <= fetch_count_reg + 32'd1;
         if (stall_inc) stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign fetch_count = fetch_count_reg;
   assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_i_fetch_stage.sv
// Bench for i_fetch_stage: directed scenarios with literal expectations, then randomized
// memory timing / stalls / redirects checked against a transaction-level model.
module tb_i_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b0, ifid_write = 1'b0, pc_src = 1'b0;
   logic [31:0] pc_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instruction_out, npc_out;
   logic        valid_out;

   int n_tests = 0;
   int n_fail  = 0;

   i_fetch_stage dut (
      .CLK(clk), .RST(rst), .PCWrite(pc_write), .IFIDWrite(ifid_write),
      .pc_src(pc_src), .pc_target(pc_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instruction_out(instruction_out), .npc_out(npc_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   // Transaction-level model: PC, one in-flight fetch (maybe to be dropped), one parked word, IF/ID.
   logic [31:0] m_pc, m_buf, m_instr, m_npc;
   logic        m_inflight, m_drop, m_have_buf, m_valid;

   // Bench-side memory: one outstanding read with a random response delay.
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_dly;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hC0DE};
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_buf = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
      m_inflight = 1'b0; m_drop = 1'b0; m_have_buf = 1'b0; m_valid = 1'b0;
      mem_busy = 1'b0; mem_dly = 0; mem_addr = 32'h0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all();
      logic m_req;
      m_req = !m_inflight && !m_have_buf;
      chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("instruction_out", instruction_out, m_instr);
      chk("npc_out", npc_out, m_npc);
      chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
   endtask

   // Drive one cycle of inputs, advance the model to the post-edge state, then compare at negedge.
   task automatic step(input logic pw, input logic iw, input logic src, input logic [31:0] tgt,
                       input logic ack, input logic rv, input logic [31:0] rd);
      logic        m_req, resp, load;
      logic [31:0] ld;
      pc_write = pw; ifid_write = iw; pc_src = src; pc_target = tgt;
      imem_ack = ack; imem_rvalid = rv; imem_rdata = rd;

      m_req = !m_inflight && !m_have_buf;
      resp  = rv && m_inflight;
      load  = 1'b0;
      ld    = 32'h0;
      if (src) begin
         m_pc = tgt & 32'hFFFF_FFFC;
         m_instr = 32'h0; m_valid = 1'b0; m_have_buf = 1'b0;
         if (m_req && ack) begin m_inflight = 1'b1; m_drop = 1'b1; end
         else if (m_inflight) begin
            if (resp) begin m_inflight = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
         end
      end else begin
         if (m_req && ack) begin m_inflight = 1'b1; m_drop = 1'b0; end
         else if (resp) begin
            m_inflight = 1'b0;
            if (m_drop) m_drop = 1'b0;
            else if (pw && iw) begin load = 1'b1; ld = rd; end
            else begin m_have_buf = 1'b1; m_buf = rd; end
         end else if (m_have_buf && pw && iw) begin
            load = 1'b1; ld = m_buf; m_have_buf = 1'b0;
         end
         if (load) begin
            m_instr = ld; m_npc = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end else if (iw) begin
            m_instr = 32'h0; m_valid = 1'b0;
         end
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_npc", npc_out, 32'h0);
      chk("rst_instr", instruction_out, 32'h0);
      rst = 1'b0;
      #1 check_all();

      // Zero-wait memory, two instructions.
      step(1, 1, 0, 0, 1, 0, 0);
      chk("zw_req_wait", {31'h0, imem_req}, 32'h0);
      step(1, 1, 0, 0, 1, 1, 32'h2001_0005);
      chk("zw_i0", instruction_out, 32'h2001_0005);
      chk("zw_npc0", npc_out, 32'd4);
      chk("zw_addr4", imem_addr, 32'd4);
      step(1, 1, 0, 0, 1, 0, 0);
      chk("zw_bubble", {31'h0, valid_out}, 32'h0);
      step(1, 1, 0, 0, 1, 1, 32'h2002_0003);
      chk("zw_i1", instruction_out, 32'h2002_0003);
      chk("zw_npc1", npc_out, 32'd8);

      // Stall while data for addr 8 arrives, then release.
      step(1, 1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h3C00_0008);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("hold_pc", imem_addr, 32'd8);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("hold_i", instruction_out, 32'h3C00_0008);
      chk("hold_npc", npc_out, 32'd12);
      chk("hold_valid", {31'h0, valid_out}, 32'h1);
      chk("hold_next", imem_addr, 32'd12);

      // Redirect while waiting: late data must be dropped.
      step(1, 1, 0, 0, 1, 0, 0);
      step(1, 1, 1, 32'h0000_0043, 0, 0, 0);
      chk("rw_valid", {31'h0, valid_out}, 32'h0);
      step(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("rw_addr", imem_addr, 32'h0000_0040);
      chk("rw_req", {31'h0, imem_req}, 32'h1);
      chk("rw_instr", instruction_out, 32'h0);

      // Redirect during a stalled hold wins.
      step(1, 1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h1111_1111);
      step(0, 0, 1, 32'h0000_0100, 0, 0, 0);
      chk("rh_addr", imem_addr, 32'h0000_0100);
      chk("rh_instr", instruction_out, 32'h0);
      chk("rh_valid", {31'h0, valid_out}, 32'h0);

      // PC wrap.
      step(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 1, 32'h2222_2222);
      chk("wrap_npc", npc_out, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_instr", instruction_out, 32'h2222_2222);

      // Async reset mid-wait; IF/ID held so the reset is visible.
      step(1, 0, 0, 0, 1, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_req", {31'h0, imem_req}, 32'h0);
      chk("arst_valid", {31'h0, valid_out}, 32'h0);
      chk("arst_instr", instruction_out, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1, 1, 0, 0, 0, 1, 32'h3333_3333);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_late", {31'h0, valid_out}, 32'h0);

      // Randomized phase.
      for (int i = 0; i < 4000; i++) begin
         logic        pw, iw, src, ack, rv;
         logic [31:0] tgt, rd;
         pw  = ($urandom_range(0, 9) < 8);
         iw  = ($urandom_range(0, 9) < 8);
         src = ($urandom_range(0, 99) < 8);
         tgt = $urandom();
         ack = 1'b0; rv = 1'b0; rd = $urandom();
         if (mem_busy) begin
            if (mem_dly == 0) begin
               rv = 1'b1; rd = mem_word(mem_addr); mem_busy = 1'b0;
            end else mem_dly--;
         end else begin
            if (!m_inflight && !m_have_buf) begin
               ack = ($urandom_range(0, 9) < 6);
               if (ack) begin
                  mem_busy = 1'b1; mem_addr = m_pc; mem_dly = $urandom_range(0, 3);
               end
            end
            if ($urandom_range(0, 99) < 15) rv = 1'b1;
         end
         step(pw, iw, src, tgt, ack, rv, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
